// File: rtl/hit_window_counter.sv
// hit_window_counter
//   Counts how many verdicts in each window of WINDOW consecutive upstream
//   verdicts are hits, and hands each count to the next stage.
//
//   Handshake (both ports, active-low valid dav_*, active-high ready rfd_*):
//     idle: rfd=1, dav_=1. Producer drives data and pulls dav_ low; the consumer
//     takes the data on that edge and drops rfd; the producer then releases dav_
//     high; the consumer raises rfd again once it can accept the next item.
//     Upstream side: this block is the consumer (dav_in_/rfd_in).
//     Downstream side: this block is the producer (dav_out_/rfd_out).
//
//   Optional feature macro: HWC_STREAK_EN
//     defined   -> max_streak reports the longest run of consecutive hits in the
//                  window that produced count.
//     undefined -> max_streak is tied to 0 and no streak logic exists.
//   The FSM and handshake timing are the same in both builds.
//
//   dbg_state exposes the FSM state encoding
//   (0 = W_DATA, 1 = W_REL, 2 = OUT, 3 = OUT_REL).

module hit_window_counter #(
  parameter int WINDOW  = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset_,
  input  logic               dav_in_,
  output logic               rfd_in,
  input  logic               z_in,
  output logic               dav_out_,
  input  logic               rfd_out,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] max_streak,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    W_DATA  = 2'd0,  // waiting for an upstream verdict
    W_REL   = 2'd1,  // verdict taken, waiting for upstream to release dav_in_
    OUT     = 2'd2,  // window result offered downstream
    OUT_REL = 2'd3   // result taken, waiting for downstream to raise rfd_out
  } state_t;

  localparam logic [COUNT_W-1:0] WINDOW_C = COUNT_W'(WINDOW);

  state_t             state,    state_nx;
  logic [COUNT_W-1:0] n,        n_nx;
  logic [COUNT_W-1:0] hits,     hits_nx;
  logic [COUNT_W-1:0] count_nx;
  logic               rfd_in_nx;
  logic               dav_out_nx;

  assign dbg_state = state;

  // Next-state and next-output logic for the handshake FSM and window counters.
  always_comb begin
    state_nx   = state;
    n_nx       = n;
    hits_nx    = hits;
    count_nx   = count;
    rfd_in_nx  = rfd_in;
    dav_out_nx = dav_out_;
    case (state)
      W_DATA: begin
        if (!dav_in_) begin
          // Sample exactly once; W_REL absorbs however long dav_in_ stays low.
          hits_nx   = hits + COUNT_W'(z_in);
          n_nx      = n + 1'b1;
          rfd_in_nx = 1'b0;
          state_nx  = W_REL;
        end
      end
      W_REL: begin
        if (dav_in_) begin
          if (n < WINDOW_C) begin
            rfd_in_nx = 1'b1;
            state_nx  = W_DATA;
          end else begin
            // Window complete: publish and keep upstream stalled until the
            // downstream handshake finishes (no output buffering).
            count_nx   = hits;
            n_nx       = '0;
            hits_nx    = '0;
            dav_out_nx = 1'b0;
            state_nx   = OUT;
          end
        end
      end
      OUT: begin
        if (!rfd_out) begin
          dav_out_nx = 1'b1;
          state_nx   = OUT_REL;
        end
      end
      OUT_REL: begin
        if (rfd_out) begin
          rfd_in_nx = 1'b1;
          state_nx  = W_DATA;
        end
      end
      default: begin
        state_nx = W_DATA;
      end
    endcase
  end

  // State and output registers; reset discards any partial window or pending result.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state    <= W_DATA;
      n        <= '0;
      hits     <= '0;
      count    <= '0;
      rfd_in   <= 1'b1;
      dav_out_ <= 1'b1;
    end else begin
      state    <= state_nx;
      n        <= n_nx;
      hits     <= hits_nx;
      count    <= count_nx;
      rfd_in   <= rfd_in_nx;
      dav_out_ <= dav_out_nx;
    end
  end

`ifdef HWC_STREAK_EN

  logic               sample_en;
  logic               close_en;
  logic [COUNT_W-1:0] cur,        cur_nx;
  logic [COUNT_W-1:0] mx,         mx_nx;
  logic [COUNT_W-1:0] streak_nx;

  // Same sample and window-close events that the FSM acts on.
  assign sample_en = (state == W_DATA) && !dav_in_;
  assign close_en  = (state == W_REL) && dav_in_ && (n >= WINDOW_C);

  // Run tracking: cur is the current run of hits, mx the longest run so far.
  always_comb begin
    cur_nx    = cur;
    mx_nx     = mx;
    streak_nx = max_streak;
    if (sample_en) begin
      cur_nx = z_in ? cur + 1'b1 : '0;
      mx_nx  = (cur_nx > mx) ? cur_nx : mx;
    end
    if (close_en) begin
      // cur and mx already include the window's last sample here.
      streak_nx = (mx > cur) ? mx : cur;
      cur_nx    = '0;
      mx_nx     = '0;
    end
  end

  // Streak registers; runs are cleared at every window close.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      cur        <= '0;
      mx         <= '0;
      max_streak <= '0;
    end else begin
      cur        <= cur_nx;
      mx         <= mx_nx;
      max_streak <= streak_nx;
    end
  end

`else

  assign max_streak = '0;

`endif

endmodule

// File: tb/tb_hit_window_counter.sv
// tb_hit_window_counter
//   Directed window patterns from a table, hand-written multi-cycle sequences
//   (long dav_in_ hold, slow downstream, mid-window reset), then random windows
//   checked against a reference that counts hits and longest runs directly
//   from the list of verdicts sent.

module tb_hit_window_counter;

  localparam int WINDOW  = 16;
  localparam int COUNT_W = 8;

  // ---------------- clock / reset ----------------
  logic               clock = 1'b0;
  logic               reset_;
  logic               dav_in_;
  logic               rfd_in;
  logic               z_in;
  logic               dav_out_;
  logic               rfd_out;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] max_streak;
  logic [1:0]         dbg_state;

  always #5 clock = ~clock;

  hit_window_counter #(.WINDOW(WINDOW), .COUNT_W(COUNT_W)) dut (
    .clock      (clock),
    .reset_     (reset_),
    .dav_in_    (dav_in_),
    .rfd_in     (rfd_in),
    .z_in       (z_in),
    .dav_out_   (dav_out_),
    .rfd_out    (rfd_out),
    .count      (count),
    .max_streak (max_streak),
    .dbg_state  (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- scoreboard ----------------
  logic [2*COUNT_W-1:0] exp_q[$];  // {count, max_streak} expected per window

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int model_count(input logic [WINDOW-1:0] v);
    int s = 0;
    for (int i = 0; i < WINDOW; i++) s += int'(v[i]);
    return s;
  endfunction

  function automatic int model_streak(input logic [WINDOW-1:0] v);
    int run = 0;
    int best = 0;
    for (int i = 0; i < WINDOW; i++) begin
      run = v[i] ? run + 1 : 0;
      if (run > best) best = run;
    end
`ifdef HWC_STREAK_EN
    return best;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_verdict(input logic z, input int hold, input bit last);
    int guard = 0;
    while (rfd_in !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("rfd_in_wait_timeout", rfd_in, 1);
    dav_in_ = 1'b0;
    z_in    = z;
    tick();
    check("rfd_in_drop", rfd_in, 0);
    for (int h = 1; h < hold; h++) begin
      z_in = 1'($urandom_range(0, 1));  // ignored while held
      tick();
    end
    dav_in_ = 1'b1;
    z_in    = 1'($urandom_range(0, 1));
    tick();
    if (!last) begin
      check("no_early_dav_out", dav_out_, 1);
      check("rfd_in_rearm", rfd_in, 1);
    end
  endtask

  task automatic recv_output(input int delay);
    logic [2*COUNT_W-1:0] e;
    int guard = 0;
    e = exp_q.pop_front();
    while (dav_out_ !== 1'b0 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("dav_out_wait_timeout", dav_out_, 0);
    check("count", count, e[2*COUNT_W-1:COUNT_W]);
    check("max_streak", max_streak, e[COUNT_W-1:0]);
    check("stall_rfd_in", rfd_in, 0);
    for (int d = 0; d < delay; d++) begin
      tick();
      check("hold_dav_out", dav_out_, 0);
      check("hold_count", count, e[2*COUNT_W-1:COUNT_W]);
      check("hold_stall", rfd_in, 0);
    end
    rfd_out = 1'b0;
    tick();
    check("dav_out_release", dav_out_, 1);
    check("rel_stall", rfd_in, 0);
    rfd_out = 1'b1;
    tick();
    check("rfd_in_resume", rfd_in, 1);
    check("count_after", count, e[2*COUNT_W-1:COUNT_W]);
  endtask

  task automatic run_window(input logic [WINDOW-1:0] pat, input int hold, input int delay,
                            input int exp_c, input int exp_s);
    exp_q.push_back({COUNT_W'(exp_c), COUNT_W'(exp_s)});
    for (int b = 0; b < WINDOW; b++) send_verdict(pat[b], hold, b == WINDOW - 1);
    recv_output(delay);
  endtask

  task automatic do_reset();
    reset_  = 1'b0;
    dav_in_ = 1'b1;
    rfd_out = 1'b1;
    tick();
    tick();
    check("rst_rfd_in", rfd_in, 1);
    check("rst_dav_out", dav_out_, 1);
    check("rst_count", count, 0);
    check("rst_max_streak", max_streak, 0);
    check("rst_state", dbg_state, 0);
    reset_ = 1'b1;
    tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [WINDOW-1:0] pat;
    int                hold;
    int                delay;
    int                exp_c;
    int                exp_s;  // longest run when the streak feature is built
  } vec_t;

  vec_t tbl[9];

  function automatic int streak_exp(input int s);
`ifdef HWC_STREAK_EN
    return s;
`else
    return 0;
`endif
  endfunction

  initial begin : main
    logic [WINDOW-1:0] pat;
    int hold;
    int delay;

    reset_  = 1'b0;
    dav_in_ = 1'b1;
    rfd_out = 1'b1;
    z_in    = 1'b0;

    // pattern bit i = verdict i
    tbl[0] = '{16'hFFFF, 1, 0, 16, 16};  // all hits
    tbl[1] = '{16'h5555, 1, 0,  8,  1};  // 1,0 alternating
    tbl[2] = '{16'h0000, 1, 0,  0,  0};  // all misses
    tbl[3] = '{16'h01F7, 1, 0,  8,  5};  // 1,1,1,0,1,1,1,1,1,0 then six 0
    tbl[4] = '{16'h8001, 1, 10, 2,  1};  // slow downstream
    tbl[5] = '{16'h0F0F, 5, 2,  8,  4};  // upstream holds dav_in_ low 5 cycles
    tbl[6] = '{16'hFFFE, 2, 1, 15, 15};  // first verdict a miss
    tbl[7] = '{16'h7FFF, 1, 0, 15, 15};  // last verdict a miss
    tbl[8] = '{16'hF00F, 3, 3,  8,  4};  // runs at both ends

    do_reset();

    for (int i = 0; i < 9; i++)
      run_window(tbl[i].pat, tbl[i].hold, tbl[i].delay, tbl[i].exp_c, streak_exp(tbl[i].exp_s));

    // Reset after 7 samples: the partial window must be discarded.
    for (int b = 0; b < 7; b++) send_verdict(1'b1, 1, 1'b0);
    do_reset();
    run_window(16'hFFFF, 1, 0, 16, streak_exp(16));

    // Random windows against the reference model.
    for (int w = 0; w < 25; w++) begin
      pat   = WINDOW'($urandom);
      hold  = $urandom_range(1, 3);
      delay = $urandom_range(0, 4);
      run_window(pat, hold, delay, model_count(pat), model_streak(pat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
